// File: rtl/ist_encoder_if.sv
// ============================================================================
// Module   : ist_encoder_if
// Purpose  : Bundles the request and result handshakes of the instruction
//            encoder into one interface.
// Signals  :
//   Request side  : in_valid, in_ready, fmt, opcode, rd, rs1, rs2, funct3,
//                   funct7, imm
//   Result side   : out_valid, out_ready, ist_word, ist_addr, out_err
//   Error status  : err_flag, err_cnt, clr_err
// Modports :
//   slave  - the encoder itself (consumes requests, produces words)
//   master - the loader / testbench (issues requests, consumes words)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ist_encoder_if #(
   parameter int ERR_CNT_W = 8
);
   // Request handshake and decoded fields
   logic                 in_valid;
   logic                 in_ready;
   logic [2:0]           fmt;
   logic [6:0]           opcode;
   logic [4:0]           rd;
   logic [4:0]           rs1;
   logic [4:0]           rs2;
   logic [2:0]           funct3;
   logic [6:0]           funct7;
   logic [31:0]          imm;

   // Result handshake
   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          ist_word;
   logic [31:0]          ist_addr;
   logic                 out_err;

   // Error status
   logic                 err_flag;
   logic [ERR_CNT_W-1:0] err_cnt;
   logic                 clr_err;

   modport slave (
      input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
      input  out_ready, clr_err,
      output in_ready, out_valid, ist_word, ist_addr, out_err,
      output err_flag, err_cnt
   );

   modport master (
      output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
      output out_ready, clr_err,
      input  in_ready, out_valid, ist_word, ist_addr, out_err,
      input  err_flag, err_cnt
   );
endinterface

`default_nettype wire

// File: rtl/ist_encoder.sv
// ============================================================================
// Module   : ist_encoder
// Purpose  : RV32 instruction encoder (inverse of the immediate generator).
//            Accepts decoded instruction fields, range-checks the immediate,
//            packs the instruction word and emits it with a sequential word
//            address through a single registered output stage.
// Ports    :
//   clk    - clock, all logic on the rising edge
//   rst_n  - synchronous active-low reset
//   bus    - ist_encoder_if.slave: request fields + in_valid/in_ready,
//            result word/address/error + out_valid/out_ready, and the
//            err_flag / err_cnt / clr_err status group
// Params   :
//   BASE_ADDR - byte address of the first emitted word
//   DEPTH     - words in the address window (power of 2, >= 2); wraps
//   ERR_CNT_W - width of the saturating error counter (must match bus)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ist_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 1024,
   parameter int          ERR_CNT_W = 8
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   ist_encoder_if.slave bus
);

   localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   localparam logic [2:0]  FMT_R   = 3'd0;
   localparam logic [2:0]  FMT_I   = 3'd1;
   localparam logic [2:0]  FMT_S   = 3'd2;
   localparam logic [2:0]  FMT_SB  = 3'd3;
   localparam logic [2:0]  FMT_U   = 3'd4;
   localparam logic [2:0]  FMT_UJ  = 3'd5;

   // ------------------------------------------------------------------------
   // Output stage state
   // ------------------------------------------------------------------------
   logic                 valid;
   logic [31:0]          word;
   logic [31:0]          addr;
   logic                 err_out;
   logic                 flag;
   logic [ERR_CNT_W-1:0] cnt;
   logic [IDX_W-1:0]     idx;

   logic                 in_xfer;
   logic                 out_xfer;
   logic                 ready;

   // Stage can refill whenever it is empty or its word leaves this cycle.
   assign ready    = !valid || bus.out_ready;
   assign in_xfer  = bus.in_valid && ready;
   assign out_xfer = valid && bus.out_ready;

   // ------------------------------------------------------------------------
   // Immediate range checks.
   // A two's-complement value fits in N bits when bits [31:N-1] are all
   // equal (all zeros or all ones).
   // ------------------------------------------------------------------------
   logic fits_12;
   logic fits_13;
   logic fits_21;

   assign fits_12 = (&bus.imm[31:11]) || (~|bus.imm[31:11]);
   assign fits_13 = (&bus.imm[31:12]) || (~|bus.imm[31:12]);
   assign fits_21 = (&bus.imm[31:20]) || (~|bus.imm[31:20]);

   // ------------------------------------------------------------------------
   // Field packing and error detection
   // ------------------------------------------------------------------------
   logic [31:0] packed_word;
   logic        enc_err;

   always_comb begin
      packed_word = NOP;
      enc_err     = 1'b0;
      case (bus.fmt)
         FMT_R: begin
            // R-type carries no immediate; imm is ignored entirely.
            packed_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3,
                           bus.rd, bus.opcode};
         end
         FMT_I: begin
            packed_word = {bus.imm[11:0], bus.rs1, bus.funct3,
                           bus.rd, bus.opcode};
            enc_err     = !fits_12;
         end
         FMT_S: begin
            packed_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                           bus.imm[4:0], bus.opcode};
            enc_err     = !fits_12;
         end
         FMT_SB: begin
            // Branch offsets are halfword aligned; bit 0 is not encodable.
            packed_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1,
                           bus.funct3, bus.imm[4:1], bus.imm[11],
                           bus.opcode};
            enc_err     = !fits_13 || bus.imm[0];
         end
         FMT_U: begin
            // Only the upper 20 bits are encodable; the low 12 must be zero.
            packed_word = {bus.imm[31:12], bus.rd, bus.opcode};
            enc_err     = |bus.imm[11:0];
         end
         FMT_UJ: begin
            packed_word = {bus.imm[20], bus.imm[10:1], bus.imm[11],
                           bus.imm[19:12], bus.rd, bus.opcode};
            enc_err     = !fits_21 || bus.imm[0];
         end
         default: begin
            packed_word = NOP;
            enc_err     = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Address of the word being loaded.
   // idx counts words that have left the stage. When a new word is loaded
   // in the same cycle the held word leaves, the new word takes the next
   // slot, so the pending increment is folded in here.
   // ------------------------------------------------------------------------
   logic [IDX_W-1:0] load_idx;
   logic [31:0]      load_addr;

   assign load_idx  = idx + IDX_W'(out_xfer);
   assign load_addr = BASE_ADDR + (32'(load_idx) << 2);

   // ------------------------------------------------------------------------
   // Output register, slot counter and error status
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid   <= 1'b0;
         word    <= 32'h0;
         addr    <= BASE_ADDR;
         err_out <= 1'b0;
         flag    <= 1'b0;
         cnt     <= '0;
         idx     <= '0;
      end else begin
         // DEPTH is a power of two, so natural overflow gives the wrap.
         if (out_xfer) begin
            idx <= idx + IDX_W'(1);
         end

         if (in_xfer) begin
            valid   <= 1'b1;
            word    <= enc_err ? NOP : packed_word;
            addr    <= load_addr;
            err_out <= enc_err;
         end else if (out_xfer) begin
            valid   <= 1'b0;
         end

         // A new error in the same cycle as clr_err restarts the count at 1.
         if (in_xfer && enc_err) begin
            flag <= 1'b1;
            if (bus.clr_err) begin
               cnt <= ERR_CNT_W'(1);
            end else if (cnt != {ERR_CNT_W{1'b1}}) begin
               cnt <= cnt + ERR_CNT_W'(1);
            end
         end else if (bus.clr_err) begin
            flag <= 1'b0;
            cnt  <= '0;
         end
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = valid;
   assign bus.ist_word  = word;
   assign bus.ist_addr  = addr;
   assign bus.out_err   = err_out;
   assign bus.err_flag  = flag;
   assign bus.err_cnt   = cnt;

endmodule

`default_nettype wire
